// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces one raw push-button, then
// produces a clean level plus single-cycle press/release/long/repeat pulses
// and a wrapping tally of accepted presses.
//
// Handshake note: this block has no valid/ready interfaces. Every pulse output
// is a registered, one-cycle strobe. Consumers sample it on the next posedge
// and do not apply backpressure.
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int REPEAT_CYCLES   = 4,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               button,
  output logic               btn_level,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_pulse,
  output logic               repeat_pulse,
  output logic [COUNT_W-1:0] press_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam int RPT_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESS_CHK   = 3'd1,
    PRESSED     = 3'd2,
    HELD        = 3'd3,
    RELEASE_CHK = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t              state, state_n;
  logic [DB_W-1:0]     db_cnt, db_cnt_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
  logic [RPT_W-1:0]    rpt_cnt, rpt_cnt_n;
  logic                was_held, was_held_n;
  logic                press_n, release_n, long_n, repeat_n, level_n;
  logic [COUNT_W-1:0]  count_n;

  // Synchroniser chain: the raw button enters at bit 0 and s is the oldest flop.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], button};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      rpt_cnt       <= '0;
      was_held      <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      press_count   <= '0;
    end else begin
      state         <= state_n;
      db_cnt        <= db_cnt_n;
      hold_cnt      <= hold_cnt_n;
      rpt_cnt       <= rpt_cnt_n;
      was_held      <= was_held_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      long_pulse    <= long_n;
      repeat_pulse  <= repeat_n;
      press_count   <= count_n;
    end
  end

  // Next-state, counter updates and the next values of the outputs.
  // hold_cnt and rpt_cnt are left untouched in RELEASE_CHK, so a short release
  // glitch pauses long-press/repeat timing instead of restarting it.
  always_comb begin
    state_n    = state;
    db_cnt_n   = db_cnt;
    hold_cnt_n = hold_cnt;
    rpt_cnt_n  = rpt_cnt;
    was_held_n = was_held;
    press_n    = 1'b0;
    release_n  = 1'b0;
    long_n     = 1'b0;
    repeat_n   = 1'b0;
    count_n    = press_count;

    case (state)
      IDLE: begin
        if (s) begin
          state_n  = PRESS_CHK;
          db_cnt_n = DB_W'(1);
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_n  = IDLE;
          db_cnt_n = '0;
        end else if (db_cnt == DB_LAST) begin
          state_n    = PRESSED;
          db_cnt_n   = '0;
          hold_cnt_n = '0;
          press_n    = 1'b1;
          count_n    = press_count + COUNT_W'(1);
        end else begin
          db_cnt_n = db_cnt + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_n    = RELEASE_CHK;
          db_cnt_n   = DB_W'(1);
          was_held_n = 1'b0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n   = HELD;
          rpt_cnt_n = '0;
          long_n    = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_n    = RELEASE_CHK;
          db_cnt_n   = DB_W'(1);
          was_held_n = 1'b1;
        end else if (rpt_cnt == RPT_LAST) begin
          rpt_cnt_n = '0;
          repeat_n  = 1'b1;
        end else begin
          rpt_cnt_n = rpt_cnt + RPT_W'(1);
        end
      end
      RELEASE_CHK: begin
        if (s) begin
          state_n  = was_held ? HELD : PRESSED;
          db_cnt_n = '0;
        end else if (db_cnt == DB_LAST) begin
          state_n   = IDLE;
          db_cnt_n  = '0;
          release_n = 1'b1;
        end else begin
          db_cnt_n = db_cnt + DB_W'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        db_cnt_n = '0;
      end
    endcase

    level_n = (state_n == PRESSED) || (state_n == HELD) || (state_n == RELEASE_CHK);
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with default parameters.
// Edge numbering: Ek is the k-th posedge of a sequence. The button value for
// Ek is driven before that edge, and outputs are sampled 1 ns after it.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic [7:0] press_count;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_count;

  // Clock and DUT.
  always #5 clk = ~clk;

  button_conditioner dut (
    .clk           (clk),
    .rst           (rst),
    .button        (button),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .press_count   (press_count)
  );

  // Single comparison point.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one edge, then compare every output against the expected values.
  task automatic tick(input logic b, input logic e_lvl, input logic e_prs,
                      input logic e_rel, input logic e_lng, input logic e_rpt);
    button = b;
    @(posedge clk);
    #1;
    if (e_prs) exp_count = exp_count + 8'd1;
    check_val("btn_level",     {31'd0, btn_level},     {31'd0, e_lvl});
    check_val("press_pulse",   {31'd0, press_pulse},   {31'd0, e_prs});
    check_val("release_pulse", {31'd0, release_pulse}, {31'd0, e_rel});
    check_val("long_pulse",    {31'd0, long_pulse},    {31'd0, e_lng});
    check_val("repeat_pulse",  {31'd0, repeat_pulse},  {31'd0, e_rpt});
    check_val("press_count",   {24'd0, press_count},   {24'd0, exp_count});
  endtask

  // One clean press (6 high edges) and release (6 low edges), starting from IDLE.
  task automatic press_release();
    for (int k = 0; k < 6; k++) tick(1'b1, k >= 5, k == 5, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++) tick(1'b0, r < 5, 1'b0, r == 5, 1'b0, 1'b0);
  endtask

  initial begin
    exp_count = 8'd0;
    rst    = 1'b1;
    button = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_level", {31'd0, btn_level},   32'd0);
    check_val("reset_count", {24'd0, press_count}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tick(1'b0, 0, 0, 0, 0, 0);

    // Held from E0: press at E5, long at E13, repeats at E17, E21, E25.
    for (int k = 0; k <= 26; k++)
      tick(1'b1, k >= 5, k == 5, 1'b0, k == 13,
           (k == 17) || (k == 21) || (k == 25));
    // Release from HELD: release_pulse and level drop after R5.
    for (int r = 0; r < 6; r++) tick(1'b0, r < 5, 1'b0, r == 5, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b0, 0, 0, 0, 0, 0);

    // Three-cycle press glitch: nothing is accepted.
    for (int k = 0; k < 12; k++) tick(k < 3, 0, 0, 0, 0, 0);

    // Press, then a 2-cycle low glitch at E8/E9. Three edges in RELEASE_CHK
    // pause hold timing, so long moves from E13 to E16. Repeat follows at E20.
    for (int k = 0; k <= 21; k++)
      tick(!((k == 8) || (k == 9)), k >= 5, k == 5, 1'b0, k == 16, k == 20);

    // Reset while HELD: outputs clear and no release_pulse is produced.
    rst    = 1'b1;
    button = 1'b1;
    @(posedge clk);
    #1;
    exp_count = 8'd0;
    check_val("rst_held_level",   {31'd0, btn_level},     32'd0);
    check_val("rst_held_release", {31'd0, release_pulse}, 32'd0);
    check_val("rst_held_repeat",  {31'd0, repeat_pulse},  32'd0);
    check_val("rst_held_count",   {24'd0, press_count},   32'd0);
    rst = 1'b0;
    // Still held: a fresh press arrives on the sixth edge after reset is released.
    for (int k = 0; k < 8; k++) tick(1'b1, k >= 5, k == 5, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++) tick(1'b0, r < 5, 1'b0, r == 5, 1'b0, 1'b0);

    // Run the counter through its wrap. After 255 more presses it reads 0,
    // and press_pulse must still fire on each press.
    for (int n = 0; n < 256; n++) begin
      press_release();
      if (exp_count == 8'd0) begin
        exp_q.push_back(8'd0);
        check_val("wrap_count", {24'd0, press_count}, {24'd0, exp_q.pop_front()});
      end
    end
    check_val("final_count", {24'd0, press_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time limit.
  initial begin
    #2000000;
    $display("FAIL timeout got=%0d expected=%0d", checks, 0);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
